miriscv_decode_queue: RTL and testbench
=======================================

# miriscv_decode_queue

Parametrised decode front-end for the miriscv core. It sits between fetch and the execute stage and buffers fetched instruction/PC pairs in a DEPTH-entry queue. The head entry is decoded into a registered-source bundle with a valid/ready handshake. Beyond the core's single-instruction decode it adds queueing, pipeline flush, RV32E register-range checking and explicit register-address outputs.

## Interface
Parameters:
- XLEN, 32, data/PC width
- ILEN, 32, instruction width
- DEPTH, 2, queue entries; power of two, ≥2
- RV32M, 1, M-extension instructions legal when 1
- RV32E, 0, when 1, register indices ≥16 are illegal

Ports:
- clk_i  in  1  clock, all state on rising edge
- arstn_i  in  1  reset, synchronous and active-low
- f_valid_i  in  1  fetch offers an instruction
- f_ready_o  out  1  queue accepts; = arstn_i && !full && !flush_i
- f_instr_i  in  ILEN  fetched instruction
- f_pc_i  in  XLEN  PC of f_instr_i
- flush_i  in  1  discard all queued entries (branch/trap redirect)
- d_valid_o  out  1  head entry valid; = !empty && !flush_i
- d_ready_i  in  1  execute consumes head
- d_instr_o  out  ILEN  head instruction (raw, also used as illegal-instruction tval)
- d_pc_o  out  XLEN  head PC
- d_bundle_o  out  decode_bundle_t  decoded control fields of head (operand selects, ALU/MDU op, mem we/size/req, wb src/we, fence/branch/jal/jalr/load, rs1/rs2 read enables)
- d_rs1_addr_o, d_rs2_addr_o, d_rd_addr_o  out  5 each  instr[19:15], [24:20], [11:7]
- d_illegal_o  out  1  head is illegal
- level_o  out  $clog2(DEPTH+1)  entries held

## Operation
- Storage: DEPTH×{instr, pc}; read/write pointers of $clog2(DEPTH) bits plus count register; pointers wrap modulo DEPTH.
- Push when f_valid_i && f_ready_o; pop when d_valid_o && d_ready_i. Push and pop in same cycle: both pointers advance, count unchanged (including when full: f_ready_o is 0 when full, so no push occurs then).
- Decode is combinational on the head entry only, using the core's standard RV32I(+M) decode rules with RV32M parameter.
- RV32E check (RV32E=1): violation if (rs1 read enabled && rs1[4]) || (rs2 read enabled && rs2[4]) || (wb write enabled && rd[4]). d_illegal_o = base illegal || violation.
- When d_illegal_o=1: all enables in d_bundle_o (rs1/rs2 re, mem req/we, wb we, mdu req, fence/branch/jal/jalr/load) forced 0; ALU op = ADD.
- When empty, d_bundle_o/d_instr_o content don't-care; only d_valid_o qualifies.
- Flush: while flush_i=1, f_ready_o=0, d_valid_o=0; at that edge read ptr, write ptr, count → 0. Flush beats push and pop.
- Reset (arstn_i=0 at edge): pointers, count → 0; storage not reset. During reset f_ready_o=0, d_valid_o=0, level_o=0 after first edge.

## Timing
- Latency: instruction pushed at edge N is at head with d_valid_o=1 in cycle N+1 (no fetch-to-decode bypass).
- Sustained throughput 1 instr/cycle with DEPTH≥2 when d_ready_i held 1.
- d_valid_o and head fields stable while d_valid_o && !d_ready_i (AXI-style hold); f_* must be held by fetch while f_valid_i && !f_ready_o.
- f_ready_o depends combinationally only on count, flush_i, arstn_i — not on d_ready_i.
- First push accepted in the cycle after arstn_i returns high.

## Structure
- decode_bundle_t and RV32E check helper in miriscv_decode_pkg alongside existing select/op encodings.
- One natural sub-module: miriscv_fifo_ctrl (pointers, count, full/empty, flush), reusable for the LSU queue.
- Decode logic instantiated once on the head entry; RV32E check and gating in this block.

## Test plan
- Push 0x00500093 (addi x1,x0,5) PC 0x80 into empty queue, d_ready_i=1 → d_valid_o next cycle, pc 0x80, rd=1, wb we=1, op2=IMM_I, not illegal.
- DEPTH=4, d_ready_i=0, push 5 instrs → 4 accepted, f_ready_o=0, level_o=4; release d_ready_i → pops in FIFO order, PCs 0x0,0x4,0x8,0xC.
- Full queue, flush_i pulse with f_valid_i=1 → next cycle level_o=0, d_valid_o=0, flushed-cycle instruction not stored.
- RV32E=1: add x16,x1,x2 (0x00208833) → d_illegal_o=1, wb we=0; RV32E=0 same instr → legal.
- RV32M=0: mul x3,x1,x2 (0x022081B3) → d_illegal_o=1, mdu req=0; RV32M=1 → mdu req=1, wb src MDU.
- Reset asserted mid-stream with 3 entries queued → after edge level_o=0, d_valid_o=0; random push/pop with scoreboard, 10k cycles, order and count preserved.

Source files
------------

// File: rtl/miriscv_decode_pkg.sv
// Decode encodings, the decoded-control bundle and the RV32I(+M) decoder shared by the
// miriscv front-end.
package miriscv_decode_pkg;

    typedef enum logic [1:0] {Op1Rs1, Op1Pc, Op1Zero} op1_sel_e;
    typedef enum logic [2:0] {Op2Rs2, Op2ImmI, Op2ImmU, Op2ImmS, Op2Incr} op2_sel_e;
    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra,
        AluOr, AluAnd, AluEq, AluNe, AluLt, AluGe, AluLtu, AluGeu
    } alu_op_e;
    typedef enum logic [2:0] {
        MduMul, MduMulh, MduMulhsu, MduMulhu, MduDiv, MduDivu, MduRem, MduRemu
    } mdu_op_e;
    typedef enum logic [1:0] {WbAlu, WbLsu, WbMdu} wb_src_e;

    typedef struct packed {
        op1_sel_e   op1_sel;
        op2_sel_e   op2_sel;
        alu_op_e    alu_op;
        logic       mdu_req;
        mdu_op_e    mdu_op;
        logic       mem_req;
        logic       mem_we;
        logic [2:0] mem_size;
        wb_src_e    wb_src;
        logic       wb_we;
        logic       fence;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       load;
        logic       rs1_re;
        logic       rs2_re;
    } decode_bundle_t;

    localparam decode_bundle_t BundleNop = '{
        op1_sel: Op1Rs1, op2_sel: Op2Rs2, alu_op: AluAdd, mdu_req: 1'b0, mdu_op: MduMul,
        mem_req: 1'b0, mem_we: 1'b0, mem_size: 3'd0, wb_src: WbAlu, wb_we: 1'b0,
        fence: 1'b0, branch: 1'b0, jal: 1'b0, jalr: 1'b0, load: 1'b0, rs1_re: 1'b0,
        rs2_re: 1'b0
    };

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? AluSub : AluAdd;
            3'd1:    return AluSll;
            3'd2:    return AluSlt;
            3'd3:    return AluSltu;
            3'd4:    return AluXor;
            3'd5:    return alt ? AluSra : AluSrl;
            3'd6:    return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    function automatic decode_bundle_t decode_instr(input logic [31:0] instr,
                                                    input logic rv32m,
                                                    output logic illegal);
        decode_bundle_t b;
        logic [2:0] f3;
        logic [6:0] f7;
        b       = BundleNop;
        illegal = 1'b0;
        f3      = instr[14:12];
        f7      = instr[31:25];
        case (instr[6:0])
            OpcLui: begin
                b.op1_sel = Op1Zero; b.op2_sel = Op2ImmU; b.wb_we = 1'b1;
            end
            OpcAuipc: begin
                b.op1_sel = Op1Pc; b.op2_sel = Op2ImmU; b.wb_we = 1'b1;
            end
            OpcJal: begin
                b.op1_sel = Op1Pc; b.op2_sel = Op2Incr; b.wb_we = 1'b1; b.jal = 1'b1;
            end
            OpcJalr: begin
                illegal   = (f3 != 3'd0);
                b.op1_sel = Op1Pc; b.op2_sel = Op2Incr; b.wb_we = 1'b1;
                b.jalr    = 1'b1; b.rs1_re = 1'b1;
            end
            OpcBranch: begin
                b.branch = 1'b1; b.rs1_re = 1'b1; b.rs2_re = 1'b1;
                case (f3)
                    3'd0:    b.alu_op = AluEq;
                    3'd1:    b.alu_op = AluNe;
                    3'd4:    b.alu_op = AluLt;
                    3'd5:    b.alu_op = AluGe;
                    3'd6:    b.alu_op = AluLtu;
                    3'd7:    b.alu_op = AluGeu;
                    default: illegal  = 1'b1;
                endcase
            end
            OpcLoad: begin
                illegal    = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
                b.op2_sel  = Op2ImmI; b.rs1_re = 1'b1; b.mem_req = 1'b1; b.load = 1'b1;
                b.wb_we    = 1'b1; b.wb_src = WbLsu; b.mem_size = f3;
            end
            OpcStore: begin
                illegal    = (f3 > 3'd2);
                b.op2_sel  = Op2ImmS; b.rs1_re = 1'b1; b.rs2_re = 1'b1;
                b.mem_req  = 1'b1; b.mem_we = 1'b1; b.mem_size = f3;
            end
            OpcOpImm: begin
                b.op2_sel = Op2ImmI; b.rs1_re = 1'b1; b.wb_we = 1'b1;
                // Bit 30 selects SRAI only; for ADDI it is immediate data.
                b.alu_op  = alu_from_f3(f3, (f3 == 3'd5) && instr[30]);
                if (f3 == 3'd1) illegal = (f7 != 7'b0000000);
                if (f3 == 3'd5) illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OpcOp: begin
                b.rs1_re = 1'b1; b.rs2_re = 1'b1; b.wb_we = 1'b1;
                if (f7 == 7'b0000001) begin
                    if (rv32m) begin
                        b.mdu_req = 1'b1; b.mdu_op = mdu_op_e'(f3); b.wb_src = WbMdu;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (f7 == 7'b0000000) begin
                    b.alu_op = alu_from_f3(f3, 1'b0);
                end else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    b.alu_op = alu_from_f3(f3, 1'b1);
                end else begin
                    illegal = 1'b1;
                end
            end
            OpcMiscMem: begin
                if (f3 == 3'd0) b.fence = 1'b1;
                else            illegal = 1'b1;
            end
            // Only ECALL/EBREAK are accepted; the trap itself is raised downstream.
            OpcSystem: illegal = !(instr == 32'h0000_0073 || instr == 32'h0010_0073);
            default:   illegal = 1'b1;
        endcase
        return b;
    endfunction

    function automatic logic rv32e_violation(input logic rs1_re, input logic rs2_re,
                                             input logic wb_we, input logic [31:0] instr);
        return (rs1_re && instr[19]) || (rs2_re && instr[24]) || (wb_we && instr[11]);
    endfunction

endpackage

// File: rtl/miriscv_fifo_ctrl.sv
// Pointer/count bookkeeping for a power-of-two queue; flush and reset both clear it.
module miriscv_fifo_ctrl #(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    output logic [PtrW-1:0] wr_ptr,
    output logic [PtrW-1:0] rd_ptr,
    output logic [CntW-1:0] count,
    output logic            full,
    output logic            empty
);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Pointers wrap for free because Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign full   = (count_q == CntW'(Depth));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/miriscv_decode_queue.sv
// Decode front-end: queues fetched instr/PC pairs and decodes the head entry with
// RV32E range checking and illegal-instruction gating.
module miriscv_decode_queue
    import miriscv_decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RV32M = 1,
    parameter int unsigned RV32E = 0
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic                       f_valid_i,
    output logic                       f_ready_o,
    input  logic [ILEN-1:0]            f_instr_i,
    input  logic [XLEN-1:0]            f_pc_i,
    input  logic                       flush_i,
    output logic                       d_valid_o,
    input  logic                       d_ready_i,
    output logic [ILEN-1:0]            d_instr_o,
    output logic [XLEN-1:0]            d_pc_o,
    output decode_bundle_t             d_bundle_o,
    output logic [4:0]                 d_rs1_addr_o,
    output logic [4:0]                 d_rs2_addr_o,
    output logic [4:0]                 d_rd_addr_o,
    output logic                       d_illegal_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic            push, pop, full, empty;
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [ILEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    decode_bundle_t  base_bundle;
    logic            base_illegal, e_violation;

    assign f_ready_o = arstn_i && !full && !flush_i;
    assign d_valid_o = !empty && !flush_i;
    assign push      = f_valid_i && f_ready_o;
    assign pop       = d_valid_o && d_ready_i;

    miriscv_fifo_ctrl #(
        .Depth (DEPTH)
    ) u_fifo_ctrl (
        .clk    (clk_i),
        .rst_n  (arstn_i),
        .push   (push),
        .pop    (pop),
        .flush  (flush_i),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (level_o),
        .full   (full),
        .empty  (empty)
    );

    // Storage is deliberately not reset; d_valid_o qualifies the head.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_q[wr_ptr] <= f_instr_i;
            pc_q[wr_ptr]    <= f_pc_i;
        end
    end

    assign d_instr_o    = instr_q[rd_ptr];
    assign d_pc_o       = pc_q[rd_ptr];
    assign d_rs1_addr_o = d_instr_o[19:15];
    assign d_rs2_addr_o = d_instr_o[24:20];
    assign d_rd_addr_o  = d_instr_o[11:7];

    always_comb begin
        base_illegal = 1'b0;
        e_violation  = 1'b0;
        base_bundle  = decode_instr(d_instr_o[31:0], RV32M != 0, base_illegal);
        if (RV32E != 0) begin
            e_violation = rv32e_violation(base_bundle.rs1_re, base_bundle.rs2_re,
                                          base_bundle.wb_we, d_instr_o[31:0]);
        end
        d_illegal_o = base_illegal || e_violation;
        d_bundle_o  = d_illegal_o ? BundleNop : base_bundle;
    end

endmodule

// File: tb/tb_miriscv_decode_queue.sv
// Directed and scoreboarded bench for miriscv_decode_queue (DEPTH=4 main instance plus a
// DEPTH=2 RV32E/no-M instance sharing its stimulus).
module tb_miriscv_decode_queue;
    import miriscv_decode_pkg::*;

    logic        clk = 1'b0, arstn = 1'b0, f_valid = 1'b0, flush = 1'b0, d_ready = 1'b0;
    logic [31:0] f_instr = '0, f_pc = '0;

    logic           a_f_ready, a_d_valid, a_illegal;
    logic [31:0]    a_instr, a_pc;
    decode_bundle_t a_bundle;
    logic [4:0]     a_rs1, a_rs2, a_rd;
    logic [2:0]     a_level;

    logic           b_f_ready, b_d_valid, b_illegal;
    logic [31:0]    b_instr, b_pc;
    decode_bundle_t b_bundle;
    logic [4:0]     b_rs1, b_rs2, b_rd;
    logic [1:0]     b_level;

    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    miriscv_decode_queue #(
        .XLEN (32), .ILEN (32), .DEPTH (4), .RV32M (1), .RV32E (0)
    ) dut (
        .clk_i (clk), .arstn_i (arstn), .f_valid_i (f_valid), .f_ready_o (a_f_ready),
        .f_instr_i (f_instr), .f_pc_i (f_pc), .flush_i (flush), .d_valid_o (a_d_valid),
        .d_ready_i (d_ready), .d_instr_o (a_instr), .d_pc_o (a_pc), .d_bundle_o (a_bundle),
        .d_rs1_addr_o (a_rs1), .d_rs2_addr_o (a_rs2), .d_rd_addr_o (a_rd),
        .d_illegal_o (a_illegal), .level_o (a_level)
    );

    miriscv_decode_queue #(
        .XLEN (32), .ILEN (32), .DEPTH (2), .RV32M (0), .RV32E (1)
    ) dut_e (
        .clk_i (clk), .arstn_i (arstn), .f_valid_i (f_valid), .f_ready_o (b_f_ready),
        .f_instr_i (f_instr), .f_pc_i (f_pc), .flush_i (flush), .d_valid_o (b_d_valid),
        .d_ready_i (d_ready), .d_instr_o (b_instr), .d_pc_o (b_pc), .d_bundle_o (b_bundle),
        .d_rs1_addr_o (b_rs1), .d_rs2_addr_o (b_rs2), .d_rd_addr_o (b_rd),
        .d_illegal_o (b_illegal), .level_o (b_level)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        f_valid = 1'b1; f_instr = instr; f_pc = pc;
        tick();
        f_valid = 1'b0;
        #1;
    endtask

    task automatic pop_one();
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        #1;
    endtask

    logic [31:0] sb[$];
    logic [31:0] pc_next;
    logic        exp_ready, do_push, do_pop;

    initial begin
        // Reset
        tick(); tick();
        check("rst_level", a_level, 0);
        check("rst_d_valid", a_d_valid, 0);
        check("rst_f_ready", a_f_ready, 0);
        arstn = 1'b1;
        #1;
        check("post_rst_f_ready", a_f_ready, 1);

        // Single addi x1,x0,5 at PC 0x80
        d_ready = 1'b1; f_valid = 1'b1; f_instr = 32'h0050_0093; f_pc = 32'h80;
        #1;
        check("addi_pre_valid", a_d_valid, 0);
        tick();
        f_valid = 1'b0;
        #1;
        check("addi_valid", a_d_valid, 1);
        check("addi_pc", a_pc, 32'h80);
        check("addi_rd", a_rd, 1);
        check("addi_wb_we", a_bundle.wb_we, 1);
        check("addi_op2", a_bundle.op2_sel, Op2ImmI);
        check("addi_illegal", a_illegal, 0);
        check("addi_rs1_re", a_bundle.rs1_re, 1);
        tick();
        check("addi_popped_level", a_level, 0);
        check("addi_popped_valid", a_d_valid, 0);

        // Fill with d_ready low: fifth offer is refused
        d_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            f_valid = 1'b1; f_instr = 32'h0000_0013; f_pc = 32'(4 * i);
            #1;
            check($sformatf("fill_f_ready_%0d", i), a_f_ready, (i < 4) ? 1 : 0);
            tick();
        end
        f_valid = 1'b0;
        #1;
        check("full_level", a_level, 4);
        check("full_f_ready", a_f_ready, 0);
        check("full_head_hold", a_pc, 32'h0);
        d_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("drain_valid_%0d", i), a_d_valid, 1);
            check($sformatf("drain_pc_%0d", i), a_pc, 32'(4 * i));
            tick();
        end
        check("drained_level", a_level, 0);
        d_ready = 1'b0;

        // Flush a full queue while fetch offers
        for (int i = 0; i < 4; i++) push_one(32'h0000_0013, 32'h40 + 32'(4 * i));
        check("pre_flush_level", a_level, 4);
        flush = 1'b1; f_valid = 1'b1; f_pc = 32'h100;
        #1;
        check("flush_f_ready", a_f_ready, 0);
        check("flush_d_valid", a_d_valid, 0);
        tick();
        flush = 1'b0; f_valid = 1'b0;
        #1;
        check("post_flush_level", a_level, 0);
        check("post_flush_valid", a_d_valid, 0);
        push_one(32'h0000_0013, 32'h200);
        check("post_flush_head_pc", a_pc, 32'h200);
        check("post_flush_level1", a_level, 1);
        pop_one();

        // add x16,x1,x2: legal on RV32I, illegal on RV32E
        push_one(32'h0020_8833, 32'h300);
        check("add_rd", a_rd, 16);
        check("add_rs1", a_rs1, 1);
        check("add_rs2", a_rs2, 2);
        check("add_illegal_i", a_illegal, 0);
        check("add_wb_we_i", a_bundle.wb_we, 1);
        check("add_illegal_e", b_illegal, 1);
        check("add_wb_we_e", b_bundle.wb_we, 0);
        pop_one();

        // mul x3,x1,x2: needs RV32M
        push_one(32'h0220_81B3, 32'h304);
        check("mul_illegal_m", a_illegal, 0);
        check("mul_mdu_req_m", a_bundle.mdu_req, 1);
        check("mul_wb_src_m", a_bundle.wb_src, WbMdu);
        check("mul_illegal_nom", b_illegal, 1);
        check("mul_mdu_req_nom", b_bundle.mdu_req, 0);
        pop_one();

        // sw x1,4(x2) and an all-zero word
        push_one(32'h0011_2223, 32'h308);
        check("sw_mem_req", a_bundle.mem_req, 1);
        check("sw_mem_we", a_bundle.mem_we, 1);
        check("sw_wb_we", a_bundle.wb_we, 0);
        check("sw_size", a_bundle.mem_size, 2);
        pop_one();
        push_one(32'h0000_0000, 32'h30C);
        check("zero_illegal", a_illegal, 1);
        check("zero_alu_add", a_bundle.alu_op, AluAdd);
        check("zero_mem_req", a_bundle.mem_req, 0);
        check("zero_rs1_re", a_bundle.rs1_re, 0);
        pop_one();

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) push_one(32'h0000_0013, 32'h400 + 32'(4 * i));
        check("midrst_pre_level", a_level, 3);
        arstn = 1'b0; f_valid = 1'b1;
        #1;
        check("midrst_f_ready", a_f_ready, 0);
        tick();
        check("midrst_level", a_level, 0);
        check("midrst_d_valid", a_d_valid, 0);
        arstn = 1'b1; f_valid = 1'b0;
        #1;
        check("midrst_release_f_ready", a_f_ready, 1);

        // Random push/pop against a scoreboard
        pc_next = 32'h1000;
        for (int c = 0; c < 10000; c++) begin
            f_valid = 1'($urandom_range(0, 1));
            d_ready = 1'($urandom_range(0, 1));
            f_instr = 32'h0000_0013;
            f_pc    = pc_next;
            #1;
            exp_ready = (sb.size() < 4);
            check("rnd_f_ready", a_f_ready, exp_ready);
            check("rnd_d_valid", a_d_valid, (sb.size() != 0) ? 1 : 0);
            if (sb.size() != 0) check("rnd_head_pc", a_pc, sb[0]);
            do_push = f_valid && exp_ready;
            do_pop  = (sb.size() != 0) && d_ready;
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                sb.push_back(pc_next);
                pc_next = pc_next + 32'd4;
            end
            tick();
            check("rnd_level", a_level, sb.size());
        end
        f_valid = 1'b0; d_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
